// File: rtl/hpi_txn_sequencer.sv
// HPI transaction sequencer: turns one request into a timed SETUP/STROBE/HOLD/TURN
// bus cycle on an asynchronous host-port interface, with a registered completion pulse.
module hpi_txn_sequencer #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int TURN_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  hpi_addr,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic [15:0] hpi_dout,
    output logic        hpi_dout_en,
    input  logic [15:0] hpi_din,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
    } state_t;

    // The counter is loaded with (cycles - 1) on entry and the state exits at zero.
    localparam logic [3:0] SETUP_LD  = (SETUP_CYC > 0) ? 4'(SETUP_CYC - 1) : 4'd0;
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;
    localparam logic [3:0] TURN_LD   = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

    state_t      state_r, next_state_s;
    logic [3:0]  cnt_r, next_cnt_s;
    logic        write_r, ready_r, busy_r, rsp_valid_r;
    logic        cs_n_r, rd_n_r, wr_n_r, dout_en_r;
    logic [1:0]  addr_r;
    logic [15:0] dout_r, rd_cap_r, rsp_rdata_r;
    logic        accept_s, done_s, cap_s, active_s, strobe_s, txn_write_s;
    logic [15:0] rsp_data_s;

    // Next-state/counter sequencing plus the decoded view of the next state.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        done_s       = 1'b0;
        accept_s     = req_valid & ready_r;
        cap_s        = (state_r == ST_STROBE) && (cnt_r == 4'd0);
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (SETUP_CYC > 0) begin
                        next_state_s = ST_SETUP;
                        next_cnt_s   = SETUP_LD;
                    end else begin
                        next_state_s = ST_STROBE;
                        next_cnt_s   = STROBE_LD;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_STROBE;
                    next_cnt_s   = STROBE_LD;
                end else begin
                    next_cnt_s = cnt_r - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_r != 4'd0) begin
                    next_cnt_s = cnt_r - 4'd1;
                end else if (HOLD_CYC > 0) begin
                    next_state_s = ST_HOLD;
                    next_cnt_s   = HOLD_LD;
                end else if (TURN_CYC > 0) begin
                    done_s       = 1'b1;
                    next_state_s = ST_TURN;
                    next_cnt_s   = TURN_LD;
                end else begin
                    done_s       = 1'b1;
                    next_state_s = ST_IDLE;
                    next_cnt_s   = 4'd0;
                end
            end
            ST_HOLD: begin
                if (cnt_r != 4'd0) begin
                    next_cnt_s = cnt_r - 4'd1;
                end else if (TURN_CYC > 0) begin
                    done_s       = 1'b1;
                    next_state_s = ST_TURN;
                    next_cnt_s   = TURN_LD;
                end else begin
                    done_s       = 1'b1;
                    next_state_s = ST_IDLE;
                    next_cnt_s   = 4'd0;
                end
            end
            ST_TURN: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_cnt_s   = 4'd0;
            end
        endcase
        // Pins are registered from the next state, so the accepted direction is used directly.
        txn_write_s = accept_s ? req_write : write_r;
        active_s    = (next_state_s == ST_SETUP) || (next_state_s == ST_STROBE) ||
                      (next_state_s == ST_HOLD);
        strobe_s    = (next_state_s == ST_STROBE);
        // With no HOLD the completion edge is also the capture edge.
        rsp_data_s  = write_r ? 16'h0000 : (cap_s ? hpi_din : rd_cap_r);
    end

    // State, counter, latched request, bus pins and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            write_r     <= 1'b0;
            addr_r      <= 2'd0;
            dout_r      <= 16'h0000;
            rd_cap_r    <= 16'h0000;
            cs_n_r      <= 1'b1;
            rd_n_r      <= 1'b1;
            wr_n_r      <= 1'b1;
            dout_en_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 16'h0000;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
            if (accept_s) begin
                write_r <= req_write;
                addr_r  <= req_addr;
                dout_r  <= req_wdata;
            end
            if (cap_s) begin
                rd_cap_r <= hpi_din;
            end
            cs_n_r      <= ~active_s;
            rd_n_r      <= ~(strobe_s & ~txn_write_s);
            wr_n_r      <= ~(strobe_s & txn_write_s);
            dout_en_r   <= active_s & txn_write_s;
            rsp_valid_r <= done_s;
            if (done_s) begin
                rsp_rdata_r <= rsp_data_s;
            end
            ready_r <= (next_state_s == ST_IDLE);
            busy_r  <= (next_state_s != ST_IDLE);
        end
    end

    assign req_ready   = ready_r;
    assign busy        = busy_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign hpi_addr    = addr_r;
    assign hpi_dout    = dout_r;
    assign hpi_cs_n    = cs_n_r;
    assign hpi_rd_n    = rd_n_r;
    assign hpi_wr_n    = wr_n_r;
    assign hpi_dout_en = dout_en_r;

endmodule

// File: doc/hpi_txn_sequencer.md
HPI_TXN_SEQUENCER -- requirements
Module: hpi_txn_sequencer

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles with address/CS asserted before the strobe; 0 skips SETUP.
REQ-002 Parameter STROBE_CYC, default 4: cycles the RD/WR strobe is low; legal range 1..15.
REQ-003 Parameter HOLD_CYC, default 1: cycles CS/address/write data are held after the strobe; 0 skips HOLD.
REQ-004 Parameter TURN_CYC, default 2: bus-idle cycles with CS high before the next request is accepted; 0 skips TURN.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  requester holds a transaction.
REQ-008 req_ready  out  1  sequencer can accept a transaction this cycle.
REQ-009 req_write  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  2  HPI register select (0 data, 1 mailbox, 2 address, 3 status).
REQ-011 req_wdata  in  16  write data.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  16  read data, valid with rsp_valid.
REQ-014 hpi_addr  out  2  HPI address pins.
REQ-015 hpi_cs_n, hpi_rd_n, hpi_wr_n  out  1 each  active-low chip select, read strobe, write strobe.
REQ-016 hpi_dout  out  16  data driven to the HPI bus.
REQ-017 hpi_dout_en  out  1  tristate enable for hpi_dout (1 = drive).
REQ-018 hpi_din  in  16  data from the HPI bus.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 States: IDLE, SETUP, STROBE, HOLD, TURN; a single down-counter (4 bits) times each state.
REQ-021 All HPI-side outputs, req_ready, rsp_valid and rsp_rdata are registered; no combinational path from any input to any output.
REQ-022 req_ready = 1 only in IDLE and not in reset; a transaction is accepted on an edge where req_valid && req_ready.
REQ-023 On accept: latch req_write, req_addr and req_wdata; the next state is SETUP (or STROBE when SETUP_CYC = 0).
REQ-024 In SETUP, STROBE and HOLD: hpi_cs_n = 0; hpi_addr = the latched address; hpi_dout = the latched data.
REQ-025 hpi_dout_en = 1 in SETUP/STROBE/HOLD only for writes; it is 0 in all other states and for all reads.
REQ-026 In STROBE: hpi_rd_n = 0 for reads, or hpi_wr_n = 0 for writes, for exactly STROBE_CYC cycles; the strobes are 1 in every other state.
REQ-027 Read data: hpi_din is captured on the edge ending the last STROBE cycle.
REQ-028 After HOLD (or STROBE when HOLD_CYC = 0), rsp_valid = 1 for exactly one cycle, in the first TURN cycle (or in IDLE when TURN_CYC = 0).
REQ-029 rsp_rdata carries the captured data for reads and 0x0000 for writes, and holds that value until the next rsp_valid.
REQ-030 In TURN and IDLE: hpi_cs_n = 1; hpi_addr and hpi_dout hold their last values.
REQ-031 Latency: with the accept edge at cycle 0, rsp_valid occurs at cycle 1+SETUP_CYC+STROBE_CYC+HOLD_CYC.
REQ-032 Latency: the earliest next accept is at cycle 1+SETUP_CYC+STROBE_CYC+HOLD_CYC+TURN_CYC (defaults: rsp at 7, next accept at 9).
REQ-033 A request presented while busy is not accepted; req_valid and the request fields are ignored until req_ready = 1, and no request is queued.
REQ-034 Request fields may change after the accept edge without affecting the transaction in progress.
REQ-035 hpi_rd_n and hpi_wr_n are never low in the same cycle.
REQ-036 hpi_cs_n never goes high while either strobe is low.

Reset
REQ-037 While reset = 1, the registered outputs take these values from the next edge:
- state IDLE
- hpi_cs_n = hpi_rd_n = hpi_wr_n = 1
- hpi_dout_en = 0
- hpi_addr = 0, hpi_dout = 0
- rsp_valid = 0, rsp_rdata = 0
- busy = 0, req_ready = 0
REQ-038 Reset asserted mid-transaction aborts it: strobes and CS deassert on the next edge, and no rsp_valid is produced for the aborted transaction.
REQ-039 req_ready rises on the first edge after reset deasserts.

Verification
REQ-040 Default read: accept addr=3 at cycle 0 with hpi_din=0xBEEF during STROBE -> cs_n low cycles 1-6, rd_n low cycles 2-5, rsp_valid at cycle 7 with rdata=0xBEEF, req_ready high at cycle 9.
REQ-041 Default write: accept addr=0, wdata=0x1234 -> dout_en=1 and dout=0x1234 cycles 1-6, wr_n low cycles 2-5, rd_n always 1, rsp_valid at cycle 7 with rdata=0x0000.
REQ-042 Back-to-back: req_valid held high with 3 queued requests -> accepts at cycles 0, 9, 18, and exactly 3 rsp_valid pulses.
REQ-043 Zero-parameter build (SETUP=HOLD=TURN=0, STROBE=1): read accepted at cycle 0 -> rd_n low at cycle 1 only, rsp_valid at cycle 2, next accept at cycle 2.
REQ-044 Reset at cycle 3 of a write -> at cycle 4 cs_n=1, wr_n=1, dout_en=0; no rsp_valid; req_ready=1 on the first cycle after reset drops.
REQ-045 Assertion bench over random traffic: REQ-035 and REQ-036 hold every cycle, and each transaction produces exactly one rsp_valid pulse.
